// File: rtl/mem_bus_arbiter_if.sv
// PicoRV32-native memory port bundle shared by the arbiter's upstream and downstream sides.
`timescale 1ns/1ps
interface mem_bus_arbiter_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // The requester drives the request fields; the responder returns ready/rdata.
  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for one PicoRV32 memory port: whole-transaction grants,
// round-robin or fixed priority, and a watchdog that completes hung accesses.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_bus_arbiter_if.slave   m0,
  mem_bus_arbiter_if.slave   m1,
  mem_bus_arbiter_if.master  s,
  output logic [1:0]         grant,
  output logic               timeout_err,
  output logic               timeout_id,
  input  logic               err_clear
);

  localparam int unsigned CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] SAT_C = {CW{1'b1}};
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam bit WD_EN_C = (TIMEOUT > 0);
  localparam bit FIXED_C = (FIXED_PRIO != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          last_owner_r;
  logic          last_owner_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          timeout_err_r;
  logic          timeout_id_r;

  logic          owner_s;
  logic          sel_valid_s;
  logic          sel_instr_s;
  logic [31:0]   sel_addr_s;
  logic [31:0]   sel_wdata_s;
  logic [3:0]    sel_wstrb_s;
  logic          done_s;
  logic          fire_s;

  // Request fields of the master named by the grant state.
  always_comb begin
    owner_s = (state_r == GNT1);
    if (owner_s) begin
      sel_valid_s = m1.mem_valid;
      sel_instr_s = m1.mem_instr;
      sel_addr_s  = m1.mem_addr;
      sel_wdata_s = m1.mem_wdata;
      sel_wstrb_s = m1.mem_wstrb;
    end else begin
      sel_valid_s = m0.mem_valid;
      sel_instr_s = m0.mem_instr;
      sel_addr_s  = m0.mem_addr;
      sel_wdata_s = m0.mem_wdata;
      sel_wstrb_s = m0.mem_wstrb;
    end
  end

  // Next-state, watchdog and bus steering.
  always_comb begin
    state_nxt_s      = state_r;
    last_owner_nxt_s = last_owner_r;
    cnt_nxt_s        = cnt_r;
    done_s           = 1'b0;
    fire_s           = 1'b0;
    s.mem_valid      = 1'b0;
    s.mem_instr      = 1'b0;
    s.mem_addr       = 32'h0000_0000;
    s.mem_wdata      = 32'h0000_0000;
    s.mem_wstrb      = 4'b0000;
    m0.mem_ready     = 1'b0;
    m1.mem_ready     = 1'b0;
    m0.mem_rdata     = s.mem_rdata;
    m1.mem_rdata     = s.mem_rdata;

    case (state_r)
      IDLE: begin
        cnt_nxt_s = ZERO_C;
        if (m0.mem_valid && m1.mem_valid) begin
          if (FIXED_C || last_owner_r) begin
            state_nxt_s = GNT0;
          end else begin
            state_nxt_s = GNT1;
          end
        end else if (m0.mem_valid) begin
          state_nxt_s = GNT0;
        end else if (m1.mem_valid) begin
          state_nxt_s = GNT1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT0, GNT1: begin
        s.mem_valid = sel_valid_s;
        s.mem_instr = sel_instr_s;
        s.mem_addr  = sel_addr_s;
        s.mem_wdata = sel_wdata_s;
        s.mem_wstrb = sel_wstrb_s;
        if (!sel_valid_s) begin
          // Owner walked away mid-transaction: release without a ready.
          state_nxt_s = IDLE;
          cnt_nxt_s   = ZERO_C;
        end else if (s.mem_ready) begin
          done_s           = 1'b1;
          state_nxt_s      = IDLE;
          last_owner_nxt_s = owner_s;
          cnt_nxt_s        = ZERO_C;
        end else if (WD_EN_C && (cnt_r == TMO_C)) begin
          fire_s           = 1'b1;
          s.mem_valid      = 1'b0;
          state_nxt_s      = IDLE;
          last_owner_nxt_s = owner_s;
          cnt_nxt_s        = ZERO_C;
        end else begin
          if (cnt_r != SAT_C) begin
            cnt_nxt_s = cnt_r + 1'b1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = ZERO_C;
      end
    endcase

    if (done_s || fire_s) begin
      if (owner_s) begin
        m1.mem_ready = 1'b1;
      end else begin
        m0.mem_ready = 1'b1;
      end
    end else begin
      m0.mem_ready = 1'b0;
      m1.mem_ready = 1'b0;
    end

    if (fire_s) begin
      if (owner_s) begin
        m1.mem_rdata = ERR_RDATA;
      end else begin
        m0.mem_rdata = ERR_RDATA;
      end
    end else begin
      m0.mem_rdata = s.mem_rdata;
      m1.mem_rdata = s.mem_rdata;
    end
  end

  // State, fairness pointer, watchdog counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      last_owner_r  <= 1'b1;
      cnt_r         <= ZERO_C;
      timeout_err_r <= 1'b0;
      timeout_id_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      cnt_r        <= cnt_nxt_s;
      if (fire_s) begin
        timeout_err_r <= 1'b1;
        timeout_id_r  <= owner_s;
      end else if (err_clear) begin
        timeout_err_r <= 1'b0;
      end
    end
  end

  // One-hot owner view of the state register.
  always_comb begin
    case (state_r)
      GNT0:    grant = 2'b01;
      GNT1:    grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign timeout_err = timeout_err_r;
  assign timeout_id  = timeout_id_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: u_rr is round-robin (TIMEOUT 8), u_fp is fixed-priority (TIMEOUT 4).
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic a_err_clear = 1'b0;
  logic b_err_clear = 1'b0;
  logic [1:0] a_grant, b_grant;
  logic a_terr, a_tid, b_terr, b_tid;

  always #5 clk = ~clk;

  mem_bus_arbiter_if a_m0 ();
  mem_bus_arbiter_if a_m1 ();
  mem_bus_arbiter_if a_s ();
  mem_bus_arbiter_if b_m0 ();
  mem_bus_arbiter_if b_m1 ();
  mem_bus_arbiter_if b_s ();

  mem_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF)) u_rr (
    .clk(clk), .reset_n(reset_n), .m0(a_m0), .m1(a_m1), .s(a_s),
    .grant(a_grant), .timeout_err(a_terr), .timeout_id(a_tid), .err_clear(a_err_clear));

  mem_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT(4), .ERR_RDATA(32'hDEADBEEF)) u_fp (
    .clk(clk), .reset_n(reset_n), .m0(b_m0), .m1(b_m1), .s(b_s),
    .grant(b_grant), .timeout_err(b_terr), .timeout_id(b_tid), .err_clear(b_err_clear));

  // Slave models: ready after lat cycles of valid, or never; rdata derived from address.
  logic [7:0] lat_a = 8'd1, lat_b = 8'd1, wc_a = 8'd0, wc_b = 8'd0;
  logic nev_a = 1'b0, nev_b = 1'b0;
  always @(posedge clk) wc_a <= (a_s.mem_valid && !a_s.mem_ready) ? wc_a + 8'd1 : 8'd0;
  always @(posedge clk) wc_b <= (b_s.mem_valid && !b_s.mem_ready) ? wc_b + 8'd1 : 8'd0;
  assign a_s.mem_ready = !nev_a && (wc_a == lat_a);
  assign b_s.mem_ready = !nev_b && (wc_b == lat_b);
  assign a_s.mem_rdata = (a_s.mem_addr == 32'h100) ? 32'h12345678 : (a_s.mem_addr ^ 32'hA5A5_0000);
  assign b_s.mem_rdata = b_s.mem_addr ^ 32'hA5A5_0000;

  logic [3:0]  rdy_v;
  logic [31:0] rd_v [4];
  assign rdy_v = {b_m1.mem_ready, b_m0.mem_ready, a_m1.mem_ready, a_m0.mem_ready};
  assign rd_v[0] = a_m0.mem_rdata;
  assign rd_v[1] = a_m1.mem_rdata;
  assign rd_v[2] = b_m0.mem_rdata;
  assign rd_v[3] = b_m1.mem_rdata;

  typedef struct { int d; int m; logic [31:0] rdata; } exp_t;
  exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic       rec_on = 1'b0;
  logic [1:0] g_last = 2'b00;
  logic [1:0] gseq[$];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic expect_rsp(input int d, input int m, input logic [31:0] r);
    exp_t e;
    e.d = d; e.m = m; e.rdata = r;
    sb_q.push_back(e);
  endtask

  task automatic req(input int d, input int m, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] ws, input logic ins);
    case (d * 2 + m)
      0: begin a_m0.mem_addr = addr; a_m0.mem_wdata = wd; a_m0.mem_wstrb = ws; a_m0.mem_instr = ins; a_m0.mem_valid = 1'b1; end
      1: begin a_m1.mem_addr = addr; a_m1.mem_wdata = wd; a_m1.mem_wstrb = ws; a_m1.mem_instr = ins; a_m1.mem_valid = 1'b1; end
      2: begin b_m0.mem_addr = addr; b_m0.mem_wdata = wd; b_m0.mem_wstrb = ws; b_m0.mem_instr = ins; b_m0.mem_valid = 1'b1; end
      default: begin b_m1.mem_addr = addr; b_m1.mem_wdata = wd; b_m1.mem_wstrb = ws; b_m1.mem_instr = ins; b_m1.mem_valid = 1'b1; end
    endcase
  endtask

  task automatic drop(input int d, input int m);
    case (d * 2 + m)
      0: a_m0.mem_valid = 1'b0;
      1: a_m1.mem_valid = 1'b0;
      2: b_m0.mem_valid = 1'b0;
      default: b_m1.mem_valid = 1'b0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for this master's ready, then release valid on the next edge.
  task automatic serve(input int d, input int m, input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (rdy_v[d * 2 + m]) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL serve_wait: dut %0d m%0d got no ready, required one within %0d cycles", d, m, budget);
    end
    tick();
    drop(d, m);
  endtask

  // Scoreboard monitor: every ready strobe consumes one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rdy_v[i]) begin
          n_cmp++;
          if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: ready on dut %0d m%0d rdata %h, required none", i / 2, i % 2, rd_v[i]);
          end else begin
            e = sb_q.pop_front();
            if (e.d != i / 2 || e.m != i % 2 || rd_v[i] !== e.rdata) begin
              n_bad++;
              $display("FAIL sb_rsp: got dut %0d m%0d rdata %h, required dut %0d m%0d rdata %h",
                       i / 2, i % 2, rd_v[i], e.d, e.m, e.rdata);
            end
          end
        end
      end
    end
  end

  // Grant-change recorder for the round-robin ordering check.
  initial begin
    forever begin
      @(negedge clk);
      if (rec_on && a_grant != g_last) begin
        gseq.push_back(a_grant);
        g_last = a_grant;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation bound exceeded");
    $fatal(1);
  end

  initial begin
    logic [1:0] g_exp;
    a_m0.mem_valid = 1'b0; a_m0.mem_instr = 1'b0; a_m0.mem_addr = 32'h0; a_m0.mem_wdata = 32'h0; a_m0.mem_wstrb = 4'h0;
    a_m1.mem_valid = 1'b0; a_m1.mem_instr = 1'b0; a_m1.mem_addr = 32'h0; a_m1.mem_wdata = 32'h0; a_m1.mem_wstrb = 4'h0;
    b_m0.mem_valid = 1'b0; b_m0.mem_instr = 1'b0; b_m0.mem_addr = 32'h0; b_m0.mem_wdata = 32'h0; b_m0.mem_wstrb = 4'h0;
    b_m1.mem_valid = 1'b0; b_m1.mem_instr = 1'b0; b_m1.mem_addr = 32'h0; b_m1.mem_wdata = 32'h0; b_m1.mem_wstrb = 4'h0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk32("rst_grant_a", {30'd0, a_grant}, 32'd0);
    chk32("rst_grant_b", {30'd0, b_grant}, 32'd0);
    chk1("rst_svalid_a", a_s.mem_valid, 1'b0);
    chk32("rst_saddr_a", a_s.mem_addr, 32'h0);
    chk32("rst_swdata_a", a_s.mem_wdata, 32'h0);
    chk32("rst_swstrb_a", {28'd0, a_s.mem_wstrb}, 32'd0);
    chk1("rst_sinstr_a", a_s.mem_instr, 1'b0);
    chk32("rst_ready", {28'd0, rdy_v}, 32'd0);
    chk1("rst_terr", a_terr | b_terr, 1'b0);
    chk1("rst_tid", a_tid | b_tid, 1'b0);
    tick();
    reset_n = 1'b1;

    // Single m0 read, slave answers two cycles after s_mem_valid.
    lat_a = 8'd2;
    req(0, 0, 32'h100, 32'h0, 4'h0, 1'b1);
    expect_rsp(0, 0, 32'h12345678);
    @(negedge clk); chk32("t1_arb_cycle", {30'd0, a_grant}, 32'd0);
    @(negedge clk); chk32("t1_grant", {30'd0, a_grant}, 32'd1);
    chk32("t1_saddr", a_s.mem_addr, 32'h100);
    chk1("t1_sinstr", a_s.mem_instr, 1'b1);
    serve(0, 0, 20);
    @(negedge clk); chk32("t1_idle", {30'd0, a_grant}, 32'd0);

    // Round-robin: both request together, four rounds, 1-cycle slave.
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    lat_a = 8'd1;
    g_last = 2'b00; rec_on = 1'b1;
    for (int r = 0; r < 4; r++) begin
      req(0, 0, 32'h200 + 32'(r * 16), 32'h0, 4'h0, 1'b0);
      req(0, 1, 32'h300 + 32'(r * 16), 32'h0, 4'h0, 1'b0);
      expect_rsp(0, 0, (32'h200 + 32'(r * 16)) ^ 32'hA5A5_0000);
      expect_rsp(0, 1, (32'h300 + 32'(r * 16)) ^ 32'hA5A5_0000);
      fork
        serve(0, 0, 20);
        serve(0, 1, 20);
      join
    end
    @(negedge clk);
    rec_on = 1'b0;
    chk32("rr_seq_len", gseq.size(), 32'd16);
    for (int i = 0; i < gseq.size() && i < 16; i++) begin
      g_exp = (i % 4 == 0) ? 2'b01 : ((i % 4 == 2) ? 2'b10 : 2'b00);
      chk32("rr_seq", {30'd0, gseq[i]}, {30'd0, g_exp});
    end

    // m1 write arrives while m0's 5-wait write owns the bus.
    lat_a = 8'd5;
    tick();
    req(0, 0, 32'h500, 32'h11112222, 4'b0011, 1'b0);
    expect_rsp(0, 0, 32'hA5A5_0500);
    expect_rsp(0, 1, 32'hA5A5_0600);
    tick();
    req(0, 1, 32'h600, 32'hCAFEF00D, 4'b1111, 1'b0);
    fork
      serve(0, 0, 30);
      serve(0, 1, 40);
      begin
        repeat (6) begin
          @(negedge clk);
          chk32("wr_hold_grant", {30'd0, a_grant}, 32'd1);
          chk32("wr_hold_wdata", a_s.mem_wdata, 32'h11112222);
        end
        @(negedge clk); chk32("wr_gap", {30'd0, a_grant}, 32'd0);
        @(negedge clk); chk32("wr_m1_grant", {30'd0, a_grant}, 32'd2);
        chk32("wr_m1_wdata", a_s.mem_wdata, 32'hCAFEF00D);
        chk32("wr_m1_wstrb", {28'd0, a_s.mem_wstrb}, 32'hF);
        chk32("wr_m1_addr", a_s.mem_addr, 32'h600);
      end
    join

    // Reset during GNT0, then a pending pair is served m0 first.
    tick();
    req(0, 0, 32'h700, 32'h0, 4'h0, 1'b0);
    tick();
    @(negedge clk); chk32("rm_grant_before", {30'd0, a_grant}, 32'd1);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk32("rm_grant", {30'd0, a_grant}, 32'd0);
    chk1("rm_svalid", a_s.mem_valid, 1'b0);
    lat_a = 8'd1;
    req(0, 1, 32'h780, 32'h0, 4'h0, 1'b0);
    expect_rsp(0, 0, 32'hA5A5_0700);
    expect_rsp(0, 1, 32'hA5A5_0780);
    fork
      serve(0, 0, 20);
      serve(0, 1, 20);
      begin @(negedge clk); chk32("rm_m0_first", {30'd0, a_grant}, 32'd1); end
    join

    // m0 abandons its request: no ready, fairness pointer stays at m1.
    lat_a = 8'd5;
    tick();
    req(0, 0, 32'hA00, 32'h0, 4'h0, 1'b0);
    tick();
    tick();
    drop(0, 0);
    @(negedge clk); chk1("ab_svalid", a_s.mem_valid, 1'b0);
    @(negedge clk); chk32("ab_idle", {30'd0, a_grant}, 32'd0);
    lat_a = 8'd1;
    req(0, 0, 32'hA10, 32'h0, 4'h0, 1'b0);
    req(0, 1, 32'hA20, 32'h0, 4'h0, 1'b0);
    expect_rsp(0, 0, 32'hA5A5_0A10);
    expect_rsp(0, 1, 32'hA5A5_0A20);
    fork
      serve(0, 0, 20);
      serve(0, 1, 20);
    join

    // Fixed priority: m0 wins the tie even right after its own grant.
    tick();
    for (int r = 0; r < 2; r++) begin
      req(1, 0, 32'h800 + 32'(r * 16), 32'h0, 4'h0, 1'b0);
      expect_rsp(1, 0, (32'h800 + 32'(r * 16)) ^ 32'hA5A5_0000);
      serve(1, 0, 20);
      req(1, 0, 32'h880 + 32'(r * 16), 32'h0, 4'h0, 1'b0);
      req(1, 1, 32'h900 + 32'(r * 16), 32'h0, 4'h0, 1'b0);
      expect_rsp(1, 0, (32'h880 + 32'(r * 16)) ^ 32'hA5A5_0000);
      expect_rsp(1, 1, (32'h900 + 32'(r * 16)) ^ 32'hA5A5_0000);
      fork
        serve(1, 0, 20);
        serve(1, 1, 20);
        begin @(negedge clk); @(negedge clk); chk32("fp_m0_wins", {30'd0, b_grant}, 32'd1); end
      join
    end

    // Watchdog: unmapped m1 access completes with the error word on grant cycle 5.
    tick();
    nev_b = 1'b1;
    req(1, 1, 32'hF000_0000, 32'h0, 4'h0, 1'b0);
    expect_rsp(1, 1, 32'hDEADBEEF);
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk1("to_strobe_cycle", b_m1.mem_ready, (k == 5));
    end
    chk1("to_svalid_forced", b_s.mem_valid, 1'b0);
    chk1("to_err_not_yet", b_terr, 1'b0);
    tick();
    drop(1, 1);
    @(negedge clk);
    chk1("to_err_set", b_terr, 1'b1);
    chk1("to_id_m1", b_tid, 1'b1);
    chk32("to_idle", {30'd0, b_grant}, 32'd0);
    b_err_clear = 1'b1;
    tick();
    b_err_clear = 1'b0;
    @(negedge clk);
    chk1("to_err_cleared", b_terr, 1'b0);
    chk1("to_id_kept", b_tid, 1'b1);

    // Timeout coinciding with err_clear: the set wins.
    b_err_clear = 1'b1;
    req(1, 0, 32'hF000_0010, 32'h0, 4'h0, 1'b0);
    expect_rsp(1, 0, 32'hDEADBEEF);
    serve(1, 0, 20);
    @(negedge clk);
    chk1("to_set_wins", b_terr, 1'b1);
    chk1("to_id_m0", b_tid, 1'b0);
    tick();
    b_err_clear = 1'b0;
    @(negedge clk);
    chk1("to_cleared_again", b_terr, 1'b0);

    // Slave ready lands on the timeout cycle: normal completion, no error.
    nev_b = 1'b0;
    lat_b = 8'd4;
    tick();
    req(1, 0, 32'h400, 32'h0, 4'h0, 1'b0);
    expect_rsp(1, 0, 32'hA5A5_0400);
    serve(1, 0, 20);
    @(negedge clk);
    chk1("to_ready_wins", b_terr, 1'b0);

    repeat (3) @(negedge clk);
    chk32("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one PicoRV32-native memory port (slave side: RAM/peripheral fabric) between two requesters: master 0 (cpu core) and master 1 (debug loader / DMA).
- Grants one whole transaction at a time, with selectable round-robin or fixed priority.
- A per-transaction watchdog completes hung transactions with an error word, so the cpu cannot deadlock on an unmapped address.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between masters; 1 = master 0 always wins ties.
- TIMEOUT, 255: maximum wait cycles in a grant state before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEADBEEF: read data returned to the owner on timeout.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- m0_mem_valid  in  1  master 0 request
- m0_mem_instr  in  1  master 0 instruction-fetch flag
- m0_mem_addr  in  32  master 0 address
- m0_mem_wdata  in  32  master 0 write data
- m0_mem_wstrb  in  4  master 0 byte strobes (0000 = read)
- m0_mem_ready  out  1  master 0 completion strobe
- m0_mem_rdata  out  32  master 0 read data
- m1_mem_valid, m1_mem_instr, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb  in  1/1/32/32/4  master 1 request (same meaning as master 0)
- m1_mem_ready, m1_mem_rdata  out  1/32  master 1 completion strobe and read data
- s_mem_valid  out  1  slave request
- s_mem_instr  out  1  slave instruction-fetch flag
- s_mem_addr  out  32  slave address
- s_mem_wdata  out  32  slave write data
- s_mem_wstrb  out  4  slave byte strobes
- s_mem_ready  in  1  slave completion
- s_mem_rdata  in  32  slave read data
- grant  out  2  one-hot owner (00 = idle)
- timeout_err  out  1  sticky: watchdog fired
- timeout_id  out  1  master that owned the bus at the most recent timeout
- err_clear  in  1  clears timeout_err

Behaviour:
- Clock is clk; reset reset_n is synchronous, active-low. Reset applies on a clk edge with reset_n = 0, including mid-transaction.
- Reset state: state = IDLE, last_owner = 1 (so m0 wins the first round-robin), wait counter = 0, timeout_err = 0, timeout_id = 0.
- Reset output values: grant = 00, s_mem_valid = 0, s_mem_addr/wdata/wstrb/instr = 0, m*_mem_ready = 0.
- Protocol: masters hold valid and all request fields stable until they see ready = 1 for one cycle, then drop valid on the next edge.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - All slave outputs are 0.
  - If any m*_valid = 1, register the winner and move to GNTx. This adds 1 cycle of arbitration latency.
  - With exactly one requester, that master wins.
  - With both requesting: FIXED_PRIO = 1 → m0 wins; FIXED_PRIO = 0 → the master that is not last_owner wins.
- GNTx, slave side:
  - s_mem_* equal mx_mem_* combinationally; s_mem_valid = mx_mem_valid.
  - The other master sees ready = 0 and keeps waiting.
- GNTx, completion:
  - mx_mem_ready = s_mem_ready in the same cycle, combinational passthrough.
  - When s_mem_ready = 1: last_owner ← x, counter ← 0, next state IDLE.
  - Minimum transaction is 1 arbitration cycle + slave latency. Back-to-back requests from either master therefore see one IDLE cycle between grants.
- rdata: both mx_mem_rdata = s_mem_rdata except during a timeout strobe. Only the owner's ready is meaningful.
- Abandon: if mx_mem_valid drops while in GNTx without s_mem_ready (protocol violation), go to IDLE next cycle with no ready and last_owner unchanged.
- Watchdog (TIMEOUT > 0):
  - counter increments each GNTx cycle without s_mem_ready.
  - When counter == TIMEOUT and s_mem_ready = 0, in that cycle: s_mem_valid forced 0, mx_mem_ready = 1, mx_mem_rdata = ERR_RDATA.
  - On the next edge: timeout_err ← 1, timeout_id ← x, last_owner ← x, state ← IDLE.
  - If s_mem_ready arrives in the same cycle as the timeout condition, the normal completion wins and no error is recorded.
- Counter width is $clog2(TIMEOUT+1) and saturates; it never wraps.
- err_clear clears timeout_err next edge. If a timeout fires in the same cycle as err_clear, set wins.
- grant reflects the state register (GNT0 → 01, GNT1 → 10).

Test Plan:
- Single m0 read: m0_valid = 1 at addr 0x100, slave ready 2 cycles after s_mem_valid with rdata 0x12345678 → grant = 01 one cycle after request, m0_ready pulse with rdata 0x12345678, m1_ready stays 0, return to IDLE.
- Simultaneous requests, FIXED_PRIO = 0, repeated 4 times with 1-cycle slave → grant order 01, 10, 01, 10, each separated by one IDLE cycle. With FIXED_PRIO = 1 and both held continuously → m0 served each time m0 re-requests on an IDLE cycle.
- m1 write during m0 grant: m1 writes 0xCAFEF00D, wstrb 1111, while m0 waits 5 cycles → s_mem_wdata stays m0's value throughout. m1 is served only after m0_ready; m1's write is visible on the slave port with wstrb 1111.
- Timeout with TIMEOUT = 4: m1 targets an unmapped address (slave never ready) → m1_ready = 1 with rdata 0xDEADBEEF on the 5th grant cycle. timeout_err = 1, timeout_id = 1 next cycle; err_clear pulse → timeout_err = 0.
- Reset mid-transaction: reset_n = 0 during GNT0 → next cycle grant = 00, s_mem_valid = 0. After release, a pending m0 and m1 pair is served m0 first.
